// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator call scheduler: direction codes, FSM states and
// default floor geometry.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS_DEF = 8;
    localparam int unsigned FLOOR_W_DEF    = 3;

    // Same encoding as the car controller's stop/up/down opcodes.
    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StUp,
        StDown,
        StDwell
    } sched_state_e;

endpackage

// File: rtl/elevator_floor_select.sv
// Combinational SCAN candidate search: nearest pending floor at/above and at/below the
// car's current position.
module elevator_floor_select
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int unsigned FLOOR_W    = FLOOR_W_DEF
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic [FLOOR_W-1:0]    above,
    output logic                  above_vld,
    output logic [FLOOR_W-1:0]    below,
    output logic                  below_vld
);

    // Scanning downward leaves the lowest qualifying floor as the final assignment.
    always_comb begin
        above     = '0;
        above_vld = 1'b0;
        for (int i = int'(NUM_FLOORS) - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) >= cur_floor)) begin
                above     = FLOOR_W'(i);
                above_vld = 1'b1;
            end
        end
    end

    always_comb begin
        below     = '0;
        below_vld = 1'b0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (pending[i] && (FLOOR_W'(i) <= cur_floor)) begin
                below     = FLOOR_W'(i);
                below_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN-policy call scheduler: latches call buttons, dispatches destination floors to the
// car controller, clears served calls on arrival and holds a door-dwell interval.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS   = NUM_FLOORS_DEF,
    parameter int unsigned FLOOR_W      = FLOOR_W_DEF,
    parameter int unsigned DWELL_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  emergency_stop,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  arrived,
    output logic [FLOOR_W-1:0]    dest_floor,
    output logic                  dest_valid,
    output logic [1:0]            dir,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dwell
);

    localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    sched_state_e          state_q, state_d;
    logic [FLOOR_W-1:0]    dest_q, dest_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_up_q, last_up_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic                  valid_q, valid_d;
    logic [1:0]            dir_q, dir_d;
    logic                  dwell_q, dwell_d;

    logic [FLOOR_W-1:0]    above, below;
    logic                  above_vld, below_vld;
    logic [FLOOR_W-1:0]    dist_up, dist_dn;
    logic                  take_up;
    logic                  arrive_ok;
    logic [NUM_FLOORS-1:0] clr;

    elevator_floor_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_floor_select (
        .pending    (pending_q),
        .cur_floor  (cur_floor),
        .above      (above),
        .above_vld  (above_vld),
        .below      (below),
        .below_vld  (below_vld)
    );

    // Only an arrival at the current target while travelling (and not frozen) counts.
    assign arrive_ok = arrived && !emergency_stop && (cur_floor == dest_q) &&
                       ((state_q == StUp) || (state_q == StDown));

    always_comb begin
        clr = '0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (cur_floor == FLOOR_W'(i)) begin
                clr[i] = arrive_ok;
            end
        end
    end

    assign pending_d = (pending_q | call_req) & ~clr;

    // Equal distances, including a call at the current floor, resolve upward.
    assign dist_up = above - cur_floor;
    assign dist_dn = cur_floor - below;
    assign take_up = above_vld && (!below_vld || (dist_up <= dist_dn));

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        cnt_d     = cnt_q;
        last_up_d = last_up_q;

        if (!emergency_stop) begin
            unique case (state_q)
                StIdle: begin
                    if (take_up) begin
                        state_d = StUp;
                        dest_d  = above;
                    end else if (below_vld) begin
                        state_d = StDown;
                        dest_d  = below;
                    end
                end
                StUp: begin
                    if (arrive_ok) begin
                        state_d   = StDwell;
                        cnt_d     = CNT_W'(DWELL_CYCLES - 1);
                        last_up_d = 1'b1;
                    end else if (above_vld) begin
                        dest_d = above;
                    end
                end
                StDown: begin
                    if (arrive_ok) begin
                        state_d   = StDwell;
                        cnt_d     = CNT_W'(DWELL_CYCLES - 1);
                        last_up_d = 1'b0;
                    end else if (below_vld) begin
                        dest_d = below;
                    end
                end
                StDwell: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (last_up_q) begin
                        if (above_vld) begin
                            state_d = StUp;
                            dest_d  = above;
                        end else if (below_vld) begin
                            state_d = StDown;
                            dest_d  = below;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        if (below_vld) begin
                            state_d = StDown;
                            dest_d  = below;
                        end else if (above_vld) begin
                            state_d = StUp;
                            dest_d  = above;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        valid_d = !emergency_stop && ((state_d == StUp) || (state_d == StDown));
        dir_d   = DIR_IDLE;
        if (valid_d) begin
            dir_d = (state_d == StUp) ? DIR_UP : DIR_DOWN;
        end
        dwell_d = (state_d == StDwell);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            dest_q    <= '0;
            cnt_q     <= '0;
            last_up_q <= 1'b1;
            pending_q <= '0;
            valid_q   <= 1'b0;
            dir_q     <= DIR_IDLE;
            dwell_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            cnt_q     <= cnt_d;
            last_up_q <= last_up_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            dir_q     <= dir_d;
            dwell_q   <= dwell_d;
        end
    end

    assign dest_floor = dest_q;
    assign dest_valid = valid_q;
    assign dir        = dir_q;
    assign pending    = pending_q;
    assign dwell      = dwell_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Self-checking bench for elevator_call_scheduler: vector table, directed corner sequences
// and randomized traffic against a floor-list reference model.
module tb_elevator_call_scheduler;

    localparam int NF    = 8;
    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] call_req;
    logic       emergency_stop;
    logic [2:0] cur_floor;
    logic       arrived;
    logic [2:0] dest_floor;
    logic       dest_valid;
    logic [1:0] dir;
    logic [7:0] pending;
    logic       dwell;

    int n_checks = 0;
    int n_pass   = 0;

    elevator_call_scheduler #(
        .NUM_FLOORS   (NF),
        .FLOOR_W      (3),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .call_req       (call_req),
        .emergency_stop (emergency_stop),
        .cur_floor      (cur_floor),
        .arrived        (arrived),
        .dest_floor     (dest_floor),
        .dest_valid     (dest_valid),
        .dir            (dir),
        .pending        (pending),
        .dwell          (dwell)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       estop;
        logic [2:0] cur;
        logic       arr;
        logic [7:0] e_pend;
        logic [2:0] e_dest;
        logic       e_valid;
        logic [1:0] e_dir;
        logic       e_dwell;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(logic [7:0] req, logic estop, logic [2:0] cur, logic arr,
                                logic [7:0] ep, logic [2:0] ed, logic ev, logic [1:0] edir,
                                logic edw);
        vec_t v;
        v.req = req; v.estop = estop; v.cur = cur; v.arr = arr;
        v.e_pend = ep; v.e_dest = ed; v.e_valid = ev; v.e_dir = edir; v.e_dwell = edw;
        return v;
    endfunction

    function automatic logic [14:0] outs();
        return {pending, dest_floor, dest_valid, dir, dwell};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [7:0] req, input logic estop, input logic [2:0] cur,
                         input logic arr);
        call_req = req; emergency_stop = estop; cur_floor = cur; arrived = arr;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(8'h00, 1'b0, 3'd0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference model: floor list, travel mode and remaining dwell cycles.
    localparam int MIdle = 0, MTravel = 1, MDwell = 2;
    bit m_pend[NF];
    int m_mode, m_dest, m_left;
    bit m_up, m_last_up, m_estop;

    function automatic int near_up(int c);
        for (int f = c; f < NF; f++) if (m_pend[f]) return f;
        return -1;
    endfunction

    function automatic int near_dn(int c);
        for (int f = c; f >= 0; f--) if (m_pend[f]) return f;
        return -1;
    endfunction

    task automatic model_reset();
        foreach (m_pend[f]) m_pend[f] = 1'b0;
        m_mode = MIdle; m_dest = 0; m_left = 0; m_up = 1'b1; m_last_up = 1'b1;
        m_estop = 1'b0;
    endtask

    task automatic go(input bit up_dir, input int f);
        m_mode = MTravel; m_up = up_dir; m_dest = f;
    endtask

    task automatic model_step();
        int  c  = int'(cur_floor);
        int  up = near_up(c);
        int  dn = near_dn(c);
        bit  acc = !emergency_stop && m_mode == MTravel && arrived && c == m_dest;
        for (int f = 0; f < NF; f++) m_pend[f] = m_pend[f] | call_req[f];
        if (acc) m_pend[c] = 1'b0;
        m_estop = emergency_stop;
        if (!emergency_stop) begin
            if (m_mode == MIdle) begin
                if (up >= 0 && (dn < 0 || up - c <= c - dn)) go(1'b1, up);
                else if (dn >= 0) go(1'b0, dn);
            end else if (m_mode == MTravel) begin
                if (acc) begin
                    m_mode = MDwell; m_left = DWELL - 1; m_last_up = m_up;
                end else if (m_up && up >= 0) m_dest = up;
                else if (!m_up && dn >= 0) m_dest = dn;
            end else begin
                if (m_left > 0) m_left--;
                else if (m_last_up && up >= 0) go(1'b1, up);
                else if (!m_last_up && dn >= 0) go(1'b0, dn);
                else if (up >= 0) go(1'b1, up);
                else if (dn >= 0) go(1'b0, dn);
                else m_mode = MIdle;
            end
        end
    endtask

    function automatic logic [14:0] model_outs();
        logic [7:0] p;
        logic       v;
        logic [1:0] d;
        for (int f = 0; f < NF; f++) p[f] = m_pend[f];
        v = (m_mode == MTravel) && !m_estop;
        d = v ? (m_up ? 2'b01 : 2'b10) : 2'b00;
        return {p, 3'(m_dest), v, d, logic'(m_mode == MDwell)};
    endfunction

    initial begin
        // req, estop, cur, arr -> pending, dest, valid, dir, dwell
        vecs[0]  = mk(8'h20, 0, 3'd0, 0, 8'h20, 3'd0, 0, 2'b00, 0);
        vecs[1]  = mk(8'h00, 0, 3'd0, 0, 8'h20, 3'd5, 1, 2'b01, 0);
        vecs[2]  = mk(8'h00, 0, 3'd2, 0, 8'h20, 3'd5, 1, 2'b01, 0);
        vecs[3]  = mk(8'h08, 0, 3'd2, 0, 8'h28, 3'd5, 1, 2'b01, 0);
        vecs[4]  = mk(8'h00, 0, 3'd2, 0, 8'h28, 3'd3, 1, 2'b01, 0);
        vecs[5]  = mk(8'h00, 0, 3'd3, 1, 8'h20, 3'd3, 0, 2'b00, 1);
        vecs[6]  = mk(8'h00, 0, 3'd3, 0, 8'h20, 3'd3, 0, 2'b00, 1);
        vecs[7]  = mk(8'h00, 0, 3'd3, 0, 8'h20, 3'd3, 0, 2'b00, 1);
        vecs[8]  = mk(8'h00, 0, 3'd3, 0, 8'h20, 3'd3, 0, 2'b00, 1);
        vecs[9]  = mk(8'h00, 0, 3'd3, 0, 8'h20, 3'd5, 1, 2'b01, 0);
        vecs[10] = mk(8'h02, 0, 3'd4, 0, 8'h22, 3'd5, 1, 2'b01, 0);
        vecs[11] = mk(8'h00, 0, 3'd5, 1, 8'h02, 3'd5, 0, 2'b00, 1);
        vecs[12] = mk(8'h00, 0, 3'd5, 0, 8'h02, 3'd5, 0, 2'b00, 1);
        vecs[13] = mk(8'h00, 0, 3'd5, 0, 8'h02, 3'd5, 0, 2'b00, 1);
        vecs[14] = mk(8'h00, 0, 3'd5, 0, 8'h02, 3'd5, 0, 2'b00, 1);
        vecs[15] = mk(8'h00, 0, 3'd5, 0, 8'h02, 3'd1, 1, 2'b10, 0);
        vecs[16] = mk(8'h00, 1, 3'd4, 0, 8'h02, 3'd1, 0, 2'b00, 0);
        vecs[17] = mk(8'h80, 1, 3'd4, 0, 8'h82, 3'd1, 0, 2'b00, 0);
        vecs[18] = mk(8'h00, 1, 3'd1, 1, 8'h82, 3'd1, 0, 2'b00, 0);
        vecs[19] = mk(8'h00, 0, 3'd3, 0, 8'h82, 3'd1, 1, 2'b10, 0);
        vecs[20] = mk(8'h00, 0, 3'd1, 1, 8'h80, 3'd1, 0, 2'b00, 1);
        vecs[21] = mk(8'h02, 0, 3'd1, 1, 8'h82, 3'd1, 0, 2'b00, 1);
        vecs[22] = mk(8'h00, 0, 3'd1, 0, 8'h82, 3'd1, 0, 2'b00, 1);
        vecs[23] = mk(8'h00, 0, 3'd1, 0, 8'h82, 3'd1, 0, 2'b00, 1);
        vecs[24] = mk(8'h00, 0, 3'd1, 0, 8'h82, 3'd1, 1, 2'b10, 0);
        vecs[25] = mk(8'h00, 0, 3'd1, 1, 8'h80, 3'd1, 0, 2'b00, 1);

        drive(8'h00, 1'b0, 3'd0, 1'b0);
        reset = 1'b1;
        #2;
        check("reset_state", 32'(outs()), 32'h0);
        do_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].estop, vecs[i].cur, vecs[i].arr);
            tick();
            check($sformatf("vec[%0d]", i), 32'(outs()),
                  32'({vecs[i].e_pend, vecs[i].e_dest, vecs[i].e_valid, vecs[i].e_dir,
                       vecs[i].e_dwell}));
        end

        // Tie at floor 4 between 2 and 6 resolves up; then freeze and release.
        do_reset();
        drive(8'h44, 0, 3'd4, 0); tick();
        check("tie_pend", 32'(pending), 32'h44);
        drive(8'h00, 0, 3'd4, 0); tick();
        check("tie_dispatch", 32'({dest_floor, dest_valid, dir}), 32'({3'd6, 1'b1, 2'b01}));
        drive(8'h00, 1, 3'd4, 0); tick();
        check("estop_freeze", 32'({dest_valid, dir}), 32'h0);
        drive(8'h80, 1, 3'd4, 0); tick();
        check("estop_latch", 32'(pending), 32'hc4);
        drive(8'h00, 0, 3'd4, 0); tick();
        check("estop_release", 32'({dest_floor, dest_valid, dir}), 32'({3'd6, 1'b1, 2'b01}));

        // Call at the current floor; clear beats a simultaneous press.
        do_reset();
        drive(8'h10, 0, 3'd4, 0); tick();
        drive(8'h00, 0, 3'd4, 0); tick();
        check("same_floor_go", 32'({dest_floor, dest_valid, dir}), 32'({3'd4, 1'b1, 2'b01}));
        drive(8'h10, 0, 3'd4, 1); tick();
        check("clear_wins", 32'({pending, dwell}), 32'({8'h00, 1'b1}));
        drive(8'h00, 0, 3'd4, 0);
        for (int k = 0; k < DWELL - 1; k++) begin
            tick();
            check($sformatf("dwell_hold[%0d]", k), 32'(dwell), 32'h1);
        end
        tick();
        check("dwell_to_idle", 32'({dest_valid, dir, dwell}), 32'h0);
        tick();
        check("idle_stays", 32'({dest_valid, dir, dwell}), 32'h0);

        // Asynchronous reset in the middle of dwell.
        drive(8'h10, 0, 3'd4, 0); tick();
        drive(8'h00, 0, 3'd4, 0); tick();
        drive(8'h00, 0, 3'd4, 1); tick();
        drive(8'h04, 0, 3'd4, 0); tick();
        check("pre_reset_dwell", 32'({pending, dwell}), 32'({8'h04, 1'b1}));
        drive(8'h00, 0, 3'd4, 0);
        reset = 1'b1;
        #1;
        check("midreset_outs", 32'({pending, dest_valid, dir, dwell}), 32'h0);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("post_reset[%0d]", k), 32'({pending, dest_valid, dir, dwell}),
                  32'h0);
        end

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            logic [7:0] req;
            logic [2:0] cur;
            req = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            cur = ($urandom_range(0, 1) == 1) ? 3'(m_dest) : 3'($urandom_range(0, 7));
            drive(req, $urandom_range(0, 15) == 0, cur, $urandom_range(0, 3) == 0);
            @(posedge clk);
            model_step();
            @(negedge clk);
            check($sformatf("rand[%0d]", i), 32'(outs()), 32'(model_outs()));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
